// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the SoC reset sequencer.
package rst_seq_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        RELEASE   = 3'd1,
        RUN       = 3'd2,
        FAULT     = 3'd3
    } rst_seq_state_e;

    // Domain indices, in release order.
    localparam int unsigned DOMAIN_CPU    = 0;
    localparam int unsigned DOMAIN_GPU    = 1;
    localparam int unsigned DOMAIN_MEM    = 2;
    localparam int unsigned DOMAIN_PERIPH = 3;

endpackage

// File: rtl/bit_sync2.sv
// Two-flop synchronizer for a single asynchronous level signal.
module bit_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Next values: shift the raw input through two stages.
    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    // Synchronizer stages, cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// Per-domain reset release sequencer gated on sustained PLL lock.
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int unsigned NUM_DOMAINS         = 4,
    parameter int unsigned LOCK_STABLE_CYCLES  = 64,
    parameter int unsigned RELEASE_GAP_CYCLES  = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned CNT_W               = $clog2(LOCK_TIMEOUT_CYCLES + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_DOMAINS-1:0] pll_locked_i,
    input  logic                   sw_reset_req,
    output logic [NUM_DOMAINS-1:0] domain_rst_n,
    output logic                   all_ready,
    output logic                   lock_fault,
    output logic [7:0]             relock_count,
    output logic [2:0]             state_o
);

    if (LOCK_STABLE_CYCLES == 0 || RELEASE_GAP_CYCLES == 0 ||
        LOCK_TIMEOUT_CYCLES <= LOCK_STABLE_CYCLES) begin : g_bad_params
        $error("reset_sequencer: illegal timing parameters");
    end

    logic [NUM_DOMAINS-1:0] lk;
    logic                   all_lk;

    rst_seq_state_e         state_q, state_d;
    logic [CNT_W-1:0]       stable_cnt_q, stable_cnt_d;
    logic [CNT_W-1:0]       timeout_cnt_q, timeout_cnt_d;
    logic [CNT_W-1:0]       gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0]       idx_q, idx_d;
    logic [NUM_DOMAINS-1:0] domain_rst_n_q, domain_rst_n_d;
    logic                   all_ready_q, all_ready_d;
    logic                   lock_fault_q, lock_fault_d;
    logic [7:0]             relock_count_q, relock_count_d;

    logic lock_loss, timeout_hit, lock_stable, gap_done, last_domain;

    for (genvar i = 0; i < NUM_DOMAINS; i++) begin : g_sync
        bit_sync2 u_sync (
            .clk (clk),
            .rst (rst),
            .d_i (pll_locked_i[i]),
            .q_o (lk[i])
        );
    end

    assign all_lk      = &lk;
    assign lock_loss   = ((state_q == RELEASE) || (state_q == RUN)) && !all_lk;
    assign timeout_hit = (state_q == WAIT_LOCK) &&
                         (timeout_cnt_q == CNT_W'(LOCK_TIMEOUT_CYCLES - 1));
    assign lock_stable = all_lk && (stable_cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1));
    assign gap_done    = gap_cnt_q == CNT_W'(RELEASE_GAP_CYCLES - 1);
    assign last_domain = idx_q == CNT_W'(NUM_DOMAINS - 1);

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= WAIT_LOCK;
            stable_cnt_q   <= '0;
            timeout_cnt_q  <= '0;
            gap_cnt_q      <= '0;
            idx_q          <= '0;
            domain_rst_n_q <= '0;
            all_ready_q    <= 1'b0;
            lock_fault_q   <= 1'b0;
            relock_count_q <= '0;
        end else begin
            state_q        <= state_d;
            stable_cnt_q   <= stable_cnt_d;
            timeout_cnt_q  <= timeout_cnt_d;
            gap_cnt_q      <= gap_cnt_d;
            idx_q          <= idx_d;
            domain_rst_n_q <= domain_rst_n_d;
            all_ready_q    <= all_ready_d;
            lock_fault_q   <= lock_fault_d;
            relock_count_q <= relock_count_d;
        end
    end

    // Next state and counter updates; sw request outranks lock loss,
    // which outranks timeout, which outranks normal progression.
    always_comb begin
        state_d       = state_q;
        stable_cnt_d  = stable_cnt_q;
        timeout_cnt_d = timeout_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        idx_d         = idx_q;
        if (sw_reset_req || lock_loss) begin
            state_d       = WAIT_LOCK;
            stable_cnt_d  = '0;
            timeout_cnt_d = '0;
            gap_cnt_d     = '0;
            idx_d         = '0;
        end else begin
            unique case (state_q)
                WAIT_LOCK: begin
                    stable_cnt_d  = all_lk ? stable_cnt_q + CNT_W'(1) : '0;
                    timeout_cnt_d = timeout_cnt_q + CNT_W'(1);
                    if (timeout_hit) begin
                        state_d = FAULT;
                    end else if (lock_stable) begin
                        state_d       = RELEASE;
                        stable_cnt_d  = '0;
                        timeout_cnt_d = '0;
                        gap_cnt_d     = '0;
                        idx_d         = '0;
                    end
                end
                RELEASE: begin
                    if (gap_done) begin
                        gap_cnt_d = '0;
                        idx_d     = idx_q + CNT_W'(1);
                        if (last_domain) begin
                            state_d = RUN;
                        end
                    end else begin
                        gap_cnt_d = gap_cnt_q + CNT_W'(1);
                    end
                end
                RUN:     state_d = RUN;
                FAULT:   state_d = FAULT;
                default: state_d = WAIT_LOCK;
            endcase
        end
    end

    // Next values of the registered outputs.
    always_comb begin
        domain_rst_n_d = domain_rst_n_q;
        all_ready_d    = all_ready_q;
        lock_fault_d   = lock_fault_q;
        relock_count_d = relock_count_q;
        if (sw_reset_req) begin
            domain_rst_n_d = '0;
            all_ready_d    = 1'b0;
            lock_fault_d   = 1'b0;
        end else if (lock_loss) begin
            domain_rst_n_d = '0;
            all_ready_d    = 1'b0;
            relock_count_d = (relock_count_q == 8'hFF) ? 8'hFF : relock_count_q + 8'd1;
        end else begin
            unique case (state_q)
                WAIT_LOCK: begin
                    domain_rst_n_d = '0;
                    all_ready_d    = 1'b0;
                    if (timeout_hit) begin
                        lock_fault_d = 1'b1;
                    end
                end
                RELEASE: begin
                    if (gap_done) begin
                        for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
                            if (idx_q == CNT_W'(i)) begin
                                domain_rst_n_d[i] = 1'b1;
                            end
                        end
                        if (last_domain) begin
                            all_ready_d = 1'b1;
                        end
                    end
                end
                RUN:     all_ready_d = 1'b1;
                FAULT: begin
                    domain_rst_n_d = '0;
                    all_ready_d    = 1'b0;
                end
                default: begin
                    domain_rst_n_d = '0;
                    all_ready_d    = 1'b0;
                end
            endcase
        end
    end

    assign domain_rst_n = domain_rst_n_q;
    assign all_ready    = all_ready_q;
    assign lock_fault   = lock_fault_q;
    assign relock_count = relock_count_q;
    assign state_o      = state_q;

endmodule
